// File: rtl/piece_collision_ctrl_pkg.sv
// Shared board geometry, coordinate widths and types for the piece collision checker.
package piece_collision_ctrl_pkg;

    localparam int unsigned BOARD_W   = 10;
    localparam int unsigned BOARD_H   = 24;
    localparam int unsigned COORD_X_W = 5;
    localparam int unsigned COORD_Y_W = 6;
    localparam int unsigned COLOUR_W  = 6;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned CELLS     = 4;
    localparam int unsigned IDX_W     = 2;
    localparam int unsigned CNT_W     = 2;

    localparam logic [COLOUR_W-1:0] EMPTY_COLOUR = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [COORD_X_W-1:0] x;
        logic [COORD_Y_W-1:0] y;
    } cell_t;

    function automatic logic in_bounds(input cell_t c);
        return (c.x < COORD_X_W'(BOARD_W)) && (c.y < COORD_Y_W'(BOARD_H));
    endfunction

endpackage

// File: rtl/piece_collision_ctrl_if.sv
// Board-RAM read port (req/gnt with fixed read latency) shared through the arbiter.
interface piece_collision_ctrl_if;
    import piece_collision_ctrl_pkg::*;

    logic                ram_req;
    logic                ram_gnt;
    logic [ADDR_W-1:0]   ram_addr;
    logic [COLOUR_W-1:0] ram_q;

    modport master (output ram_req, output ram_addr, input ram_gnt, input ram_q);
    modport slave  (input ram_req, input ram_addr, output ram_gnt, output ram_q);

endinterface

// File: rtl/piece_collision_ctrl_coord_to_addr.sv
// Maps a board coordinate to its linear RAM address (Y*10+X, truncated to the address width).
module piece_collision_ctrl_coord_to_addr
    import piece_collision_ctrl_pkg::*;
(
    input  logic [COORD_X_W-1:0] x,
    input  logic [COORD_Y_W-1:0] y,
    output logic [ADDR_W-1:0]    addr_c
);

    localparam int unsigned FULL_W = 9;

    // In-bounds cells top out at 239, so dropping the ninth bit is lossless in use.
    assign addr_c = ADDR_W'(FULL_W'(y) * FULL_W'(BOARD_W) + FULL_W'(x));

endmodule

// File: rtl/piece_collision_ctrl.sv
// Sequences one collision check of a 4-cell piece: one board-RAM read per in-bounds cell,
// early exit on the first occupied or out-of-bounds cell, then a single done pulse.
module piece_collision_ctrl
    import piece_collision_ctrl_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         start,
    input  logic [CELLS*COORD_X_W-1:0]   cells_x,
    input  logic [CELLS*COORD_Y_W-1:0]   cells_y,
    output logic                         busy,
    output logic                         done,
    output logic                         collision,
    piece_collision_ctrl_if.master       ram
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CELLS - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    cell_t              cells_q [CELLS];

    cell_t              sel_cell_c;
    logic               sel_ok_c;
    logic [ADDR_W-1:0]  sel_addr_c;

    // Cell about to enter ISSUE: cell 0 straight from the inputs at start, else the next latched cell.
    always_comb begin
        sel_cell_c = cells_q[idx + IDX_W'(1)];
        if (state == ST_IDLE) begin
            sel_cell_c = '{x: cells_x[COORD_X_W-1:0], y: cells_y[COORD_Y_W-1:0]};
        end
    end

    assign sel_ok_c = in_bounds(sel_cell_c);

    piece_collision_ctrl_coord_to_addr u_coord_to_addr (
        .x      (sel_cell_c.x),
        .y      (sel_cell_c.y),
        .addr_c (sel_addr_c)
    );

    // ram_req is loaded with the bounds verdict on entry to ISSUE, so a low req in ISSUE marks an off-board cell.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            idx          <= '0;
            cnt          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            collision    <= 1'b0;
            ram.ram_req  <= 1'b0;
            ram.ram_addr <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < CELLS; i++) begin
                            cells_q[i] <= '{x: cells_x[i*COORD_X_W +: COORD_X_W],
                                            y: cells_y[i*COORD_Y_W +: COORD_Y_W]};
                        end
                        idx          <= '0;
                        collision    <= 1'b0;
                        busy         <= 1'b1;
                        ram.ram_req  <= sel_ok_c;
                        ram.ram_addr <= sel_addr_c;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!ram.ram_req) begin
                        collision <= 1'b1;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end else if (ram.ram_gnt) begin
                        ram.ram_req <= 1'b0;
                        cnt         <= '0;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == CNT_LAST) begin
                        if (ram.ram_q != EMPTY_COLOUR) begin
                            collision <= 1'b1;
                            done      <= 1'b1;
                            state     <= ST_DONE;
                        end else if (idx == IDX_LAST) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            idx          <= idx + IDX_W'(1);
                            ram.ram_req  <= sel_ok_c;
                            ram.ram_addr <= sel_addr_c;
                            state        <= ST_ISSUE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piece_collision_ctrl.sv
// Bench for piece_collision_ctrl: two instances (read latency 1 and 3) against a RAM/arbiter responder.
module tb_piece_collision_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  start_v;
    logic [19:0] cells_x;
    logic [23:0] cells_y;
    logic [1:0]  busy_v, done_v, coll_v, req_v, gnt_v;
    logic [7:0]  addr_v [2];
    logic [5:0]  q_v [2];

    piece_collision_ctrl_if bus0 ();
    piece_collision_ctrl_if bus1 ();

    assign req_v[0]      = bus0.ram_req;
    assign req_v[1]      = bus1.ram_req;
    assign addr_v[0]     = bus0.ram_addr;
    assign addr_v[1]     = bus1.ram_addr;
    assign bus0.ram_gnt  = gnt_v[0];
    assign bus1.ram_gnt  = gnt_v[1];
    assign bus0.ram_q    = q_v[0];
    assign bus1.ram_q    = q_v[1];

    piece_collision_ctrl #(.RD_LATENCY(1)) u_dut_l1 (
        .clk(clk), .resetn(resetn), .start(start_v[0]), .cells_x(cells_x), .cells_y(cells_y),
        .busy(busy_v[0]), .done(done_v[0]), .collision(coll_v[0]), .ram(bus0));

    piece_collision_ctrl #(.RD_LATENCY(3)) u_dut_l3 (
        .clk(clk), .resetn(resetn), .start(start_v[1]), .cells_x(cells_x), .cells_y(cells_y),
        .busy(busy_v[1]), .done(done_v[1]), .collision(coll_v[1]), .ram(bus1));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [5:0] board [256];
    int cfg_stall [2][4];
    int cfg_gen   [2];
    int exp_a     [4];

    int   seen_gen [2];
    int   rd_n     [2];
    int   rd_addr  [2][4];
    int   stab_err [2];
    bit   pend     [2];
    int   pend_cnt [2];
    int   pend_addr[2];
    int   stall_left[2];
    bit   prev_req [2];
    logic [7:0] prev_addr [2];

    // RAM + arbiter responder: grants after the configured stall, returns data exactly at the sample cycle.
    initial begin
        gnt_v = 2'b00;
        q_v[0] = 6'd0;
        q_v[1] = 6'd0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (cfg_gen[i] != seen_gen[i]) begin
                    seen_gen[i]   = cfg_gen[i];
                    rd_n[i]       = 0;
                    stab_err[i]   = 0;
                    pend[i]       = 1'b0;
                    stall_left[i] = cfg_stall[i][0];
                end
                if (pend[i] && pend_cnt[i] == 1) begin
                    q_v[i]  = board[pend_addr[i]];
                    pend[i] = 1'b0;
                end else begin
                    q_v[i] = 6'($urandom_range(1, 63));
                    if (pend[i]) pend_cnt[i]--;
                end
                if (req_v[i] === 1'b1 && prev_req[i] && addr_v[i] !== prev_addr[i]) stab_err[i]++;
                prev_req[i]  = (req_v[i] === 1'b1);
                prev_addr[i] = addr_v[i];
                if (req_v[i] === 1'b1) begin
                    if (stall_left[i] > 0) begin
                        gnt_v[i] = 1'b0;
                        stall_left[i]--;
                    end else begin
                        gnt_v[i] = 1'b1;
                        if (rd_n[i] < 4) rd_addr[i][rd_n[i]] = int'(addr_v[i]);
                        rd_n[i]++;
                        pend[i]       = 1'b1;
                        pend_cnt[i]   = (i == 0) ? 1 : 3;
                        pend_addr[i]  = int'(addr_v[i]);
                        stall_left[i] = (rd_n[i] < 4) ? cfg_stall[i][rd_n[i]] : 0;
                    end
                end else begin
                    gnt_v[i] = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // Reference: walk the cells in order; off-board or occupied ends the check, each read costs 1+lat+stall.
    task automatic model(input int inst, input logic [19:0] cx, input logic [23:0] cy,
                         output int cyc, output logic coll, output int n);
        int x, y, lat;
        lat  = (inst == 0) ? 1 : 3;
        cyc  = 1;
        coll = 1'b0;
        n    = 0;
        for (int k = 0; k < 4; k++) exp_a[k] = -1;
        for (int i = 0; i < 4; i++) begin
            if (!coll) begin
                x = int'(cx[5*i +: 5]);
                y = int'(cy[6*i +: 6]);
                if (x >= 10 || y >= 24) begin
                    coll = 1'b1;
                    cyc += 1;
                end else begin
                    exp_a[n] = y * 10 + x;
                    cyc += 1 + lat + cfg_stall[inst][n];
                    n++;
                    if (board[y*10+x] != 6'd0) coll = 1'b1;
                end
            end
        end
    endtask

    task automatic clear_cfg();
        for (int a = 0; a < 256; a++) board[a] = 6'd0;
        for (int i = 0; i < 2; i++) for (int k = 0; k < 4; k++) cfg_stall[i][k] = 0;
    endtask

    // Drives one check and records what the DUT did; scrambles the cell inputs right after the start edge.
    task automatic run_piece(input int inst, input logic [19:0] cx, input logic [23:0] cy,
                             input bit poke_busy, input bit poke_done,
                             output int d_cyc, output logic d_coll, output int busy_bad, output int tail_bad);
        int c;
        d_cyc = 0; d_coll = 1'b0; busy_bad = 0; tail_bad = 0;
        @(negedge clk);
        cfg_gen[inst]++;
        cells_x = cx;
        cells_y = cy;
        @(negedge clk);
        start_v[inst] = 1'b1;
        @(negedge clk);
        start_v[inst] = 1'b0;
        cells_x = 20'($urandom);
        cells_y = 24'($urandom);
        c = 1;
        while (d_cyc == 0 && c <= 200) begin
            if (busy_v[inst] !== 1'b1) busy_bad++;
            if (done_v[inst] === 1'b1) begin
                d_cyc  = c;
                d_coll = coll_v[inst];
                start_v[inst] = poke_done;
            end else begin
                start_v[inst] = poke_busy && (c == 3);
                @(negedge clk);
                c++;
            end
        end
        @(negedge clk);
        start_v[inst] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (done_v[inst] !== 1'b0 || busy_v[inst] !== 1'b0 || req_v[inst] !== 1'b0 ||
                coll_v[inst] !== d_coll) tail_bad++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++; if (busy_v[i] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy_v[i]); end
            checks++; if (done_v[i] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d]: got %b want 0", i, done_v[i]); end
            checks++; if (coll_v[i] !== 1'b0) begin errors++; $display("FAIL reset_coll[%0d]: got %b want 0", i, coll_v[i]); end
            checks++; if (req_v[i] !== 1'b0) begin errors++; $display("FAIL reset_req[%0d]: got %b want 0", i, req_v[i]); end
            checks++; if (addr_v[i] !== 8'd0) begin errors++; $display("FAIL reset_addr[%0d]: got %0d want 0", i, addr_v[i]); end
        end
        resetn = 1'b1;
    endtask

    task automatic test_empty_board();
        int d_cyc, bb, tb; logic d_coll;
        int want [4] = '{4, 5, 14, 15};
        clear_cfg();
        run_piece(0, {5'd5, 5'd4, 5'd5, 5'd4}, {6'd1, 6'd1, 6'd0, 6'd0}, 1'b0, 1'b0, d_cyc, d_coll, bb, tb);
        checks++; if (d_cyc !== 9) begin errors++; $display("FAIL empty_done_cycle: got %0d want 9", d_cyc); end
        checks++; if (d_coll !== 1'b0) begin errors++; $display("FAIL empty_collision: got %b want 0", d_coll); end
        checks++; if (rd_n[0] !== 4) begin errors++; $display("FAIL empty_reads: got %0d want 4", rd_n[0]); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (rd_addr[0][k] !== want[k]) begin errors++; $display("FAIL empty_addr[%0d]: got %0d want %0d", k, rd_addr[0][k], want[k]); end
        end
        checks++; if (bb !== 0 || tb !== 0) begin errors++; $display("FAIL empty_busy_tail: got %0d/%0d want 0/0", bb, tb); end
    endtask

    task automatic test_collision_mid();
        int d_cyc, bb, tb; logic d_coll;
        clear_cfg();
        board[14] = 6'h3F;
        run_piece(0, {5'd5, 5'd4, 5'd5, 5'd4}, {6'd1, 6'd1, 6'd0, 6'd0}, 1'b0, 1'b0, d_cyc, d_coll, bb, tb);
        checks++; if (d_cyc !== 7) begin errors++; $display("FAIL mid_done_cycle: got %0d want 7", d_cyc); end
        checks++; if (d_coll !== 1'b1) begin errors++; $display("FAIL mid_collision: got %b want 1", d_coll); end
        checks++; if (rd_n[0] !== 3 || rd_addr[0][2] !== 14) begin errors++; $display("FAIL mid_reads: got %0d reads last %0d want 3 last 14", rd_n[0], rd_addr[0][2]); end
        checks++; if (tb !== 0) begin errors++; $display("FAIL mid_held: got %0d bad tail cycles want 0", tb); end
    endtask

    task automatic test_out_of_bounds();
        int d_cyc, bb, tb; logic d_coll;
        clear_cfg();
        run_piece(0, {5'd0, 5'd0, 5'd0, 5'd10}, {6'd0, 6'd0, 6'd0, 6'd3}, 1'b0, 1'b0, d_cyc, d_coll, bb, tb);
        checks++; if (d_cyc !== 2) begin errors++; $display("FAIL oob0_done_cycle: got %0d want 2", d_cyc); end
        checks++; if (d_coll !== 1'b1) begin errors++; $display("FAIL oob0_collision: got %b want 1", d_coll); end
        checks++; if (rd_n[0] !== 0) begin errors++; $display("FAIL oob0_reads: got %0d want 0", rd_n[0]); end
        run_piece(0, 20'd0, {6'd0, 6'd24, 6'd0, 6'd0}, 1'b0, 1'b0, d_cyc, d_coll, bb, tb);
        checks++; if (d_cyc !== 6) begin errors++; $display("FAIL oob2_done_cycle: got %0d want 6", d_cyc); end
        checks++; if (d_coll !== 1'b1) begin errors++; $display("FAIL oob2_collision: got %b want 1", d_coll); end
        checks++; if (rd_n[0] !== 2 || rd_addr[0][0] !== 0 || rd_addr[0][1] !== 0) begin
            errors++; $display("FAIL oob2_reads: got %0d reads (%0d,%0d) want 2 (0,0)", rd_n[0], rd_addr[0][0], rd_addr[0][1]); end
    endtask

    task automatic test_stall_ignored_start();
        int d_cyc, bb, tb; logic d_coll;
        clear_cfg();
        cfg_stall[0][0] = 5;
        run_piece(0, {5'd5, 5'd4, 5'd5, 5'd4}, {6'd1, 6'd1, 6'd0, 6'd0}, 1'b1, 1'b1, d_cyc, d_coll, bb, tb);
        checks++; if (d_cyc !== 14) begin errors++; $display("FAIL stall_done_cycle: got %0d want 14", d_cyc); end
        checks++; if (stab_err[0] !== 0) begin errors++; $display("FAIL stall_req_stable: got %0d changes want 0", stab_err[0]); end
        checks++; if (tb !== 0) begin errors++; $display("FAIL stall_no_second_done: got %0d bad tail cycles want 0", tb); end
        checks++; if (bb !== 0 || rd_n[0] !== 4) begin errors++; $display("FAIL stall_busy_reads: got %0d/%0d want 0/4", bb, rd_n[0]); end
    endtask

    task automatic test_latency3();
        int d_cyc, bb, tb; logic d_coll;
        clear_cfg();
        run_piece(1, {5'd5, 5'd4, 5'd5, 5'd4}, {6'd1, 6'd1, 6'd0, 6'd0}, 1'b0, 1'b0, d_cyc, d_coll, bb, tb);
        checks++; if (d_cyc !== 17) begin errors++; $display("FAIL lat3_done_cycle: got %0d want 17", d_cyc); end
        checks++; if (d_coll !== 1'b0) begin errors++; $display("FAIL lat3_collision: got %b want 0", d_coll); end
        board[5] = 6'd1;
        run_piece(1, {5'd5, 5'd4, 5'd5, 5'd4}, {6'd1, 6'd1, 6'd0, 6'd0}, 1'b0, 1'b0, d_cyc, d_coll, bb, tb);
        checks++; if (d_cyc !== 9 || d_coll !== 1'b1) begin errors++; $display("FAIL lat3_hit: got cycle %0d coll %b want 9/1", d_cyc, d_coll); end
        checks++; if (rd_n[1] !== 2) begin errors++; $display("FAIL lat3_hit_reads: got %0d want 2", rd_n[1]); end
    endtask

    task automatic test_reset_mid_wait();
        int seen;
        clear_cfg();
        @(negedge clk);
        cfg_gen[1]++;
        cells_x = {5'd5, 5'd4, 5'd5, 5'd4};
        cells_y = {6'd1, 6'd1, 6'd0, 6'd0};
        @(negedge clk);
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        checks++; if (busy_v[1] !== 1'b0 || done_v[1] !== 1'b0) begin errors++; $display("FAIL rstwait_busy_done: got %b/%b want 0/0", busy_v[1], done_v[1]); end
        checks++; if (coll_v[1] !== 1'b0) begin errors++; $display("FAIL rstwait_coll: got %b want 0", coll_v[1]); end
        checks++; if (req_v[1] !== 1'b0 || addr_v[1] !== 8'd0) begin errors++; $display("FAIL rstwait_req_addr: got %b/%0d want 0/0", req_v[1], addr_v[1]); end
        resetn = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_v[1] !== 1'b0 || req_v[1] !== 1'b0 || busy_v[1] !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstwait_abandoned: got %0d active cycles want 0", seen); end
    endtask

    task automatic test_random();
        int inst, d_cyc, bb, tb, e_cyc, e_n;
        logic d_coll, e_coll;
        logic [19:0] cx;
        logic [23:0] cy;
        for (int it = 0; it < 30; it++) begin
            clear_cfg();
            inst = int'($urandom_range(0, 1));
            for (int a = 0; a < 240; a++)
                board[a] = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            for (int k = 0; k < 4; k++) begin
                cx[5*k +: 5] = 5'($urandom_range(0, 10));
                cy[6*k +: 6] = 6'($urandom_range(0, 24));
                cfg_stall[inst][k] = int'($urandom_range(0, 2));
            end
            model(inst, cx, cy, e_cyc, e_coll, e_n);
            run_piece(inst, cx, cy, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d_cyc, d_coll, bb, tb);
            checks++; if (d_cyc !== e_cyc) begin errors++; $display("FAIL rand%0d_done_cycle: got %0d want %0d", it, d_cyc, e_cyc); end
            checks++; if (d_coll !== e_coll) begin errors++; $display("FAIL rand%0d_collision: got %b want %b", it, d_coll, e_coll); end
            checks++; if (rd_n[inst] !== e_n) begin errors++; $display("FAIL rand%0d_reads: got %0d want %0d", it, rd_n[inst], e_n); end
            for (int k = 0; k < 4; k++) begin
                if (k < e_n) begin
                    checks++; if (rd_addr[inst][k] !== exp_a[k]) begin errors++; $display("FAIL rand%0d_addr[%0d]: got %0d want %0d", it, k, rd_addr[inst][k], exp_a[k]); end
                end
            end
            checks++; if (bb !== 0 || tb !== 0 || stab_err[inst] !== 0) begin
                errors++; $display("FAIL rand%0d_protocol: got busy %0d tail %0d stab %0d want 0/0/0", it, bb, tb, stab_err[inst]); end
        end
    endtask

    initial begin
        resetn  = 1'b0;
        start_v = 2'b00;
        cells_x = '0;
        cells_y = '0;
        clear_cfg();
        test_reset();
        test_empty_board();
        test_collision_mid();
        test_out_of_bounds();
        test_stall_ignored_start();
        test_latency3();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
